keypad_scan: RTL
================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50_000, meaning clk cycles each column is driven (1 ms at 50 MHz).
REQ-002 SHALL have parameter DEB_CYCLES, default 1_000_000, meaning consecutive stable samples needed to accept a press or release (20 ms).
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port row, input, 4 bits: keypad rows, active-low, externally pulled up.
REQ-006 SHALL have port col, output, 4 bits: keypad column drive, one-hot active-low.
REQ-007 SHALL have port Tecla, output, 4 bits: debounced key code for the vending FSM; 4'b1111 means no key.
REQ-008 SHALL have port key_strobe, output, 1 bit: one-cycle pulse when a new key is accepted.

Function
REQ-009 SHALL compute key index as row*4+col+1 (row, col 0..3) and drive Tecla = ~index; key '1' gives 4'b1110, '2' gives 4'b1101, '3' gives 4'b1100, 'A' gives 4'b1011.
REQ-010 SHALL never report key D (row3, col3), because its code would equal 4'b1111; D is ignored in every state.
REQ-011 SHALL implement states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-012 SCAN: col rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, each value held SCAN_DIV cycles; row is sampled only on the last cycle of each dwell.
REQ-013 SCAN: if a sampled row is low, SHALL latch the lowest-numbered low row and the current column, freeze col, and enter DEBOUNCE.
REQ-014 DEBOUNCE: the latched row bit is checked every cycle; after DEB_CYCLES consecutive lows -> HELD, Tecla updates, and key_strobe=1 for exactly that cycle.
REQ-015 DEBOUNCE: if the latched row bit reads high -> SCAN, counter cleared, col advances to the next column, no strobe.
REQ-016 HELD: col stays frozen and Tecla is held constant; when the latched row bit reads high -> RELEASE, counter cleared.
REQ-017 RELEASE: after DEB_CYCLES consecutive highs -> Tecla=4'b1111, col advances, state SCAN.
REQ-018 RELEASE: if the row bit goes low again -> HELD, counter cleared, no new strobe, Tecla unchanged.
REQ-019 A second key pressed while HELD SHALL be ignored until the first key's release completes.
REQ-020 Counters SHALL be sized by $clog2 of their parameter, never wrap, and saturate at terminal count.
REQ-021 Tecla latency from a stable press onset SHALL be at most 4*SCAN_DIV+DEB_CYCLES+2 cycles.

Reset
REQ-022 While rst=1 at a clk edge: state=SCAN, col=4'b1110, Tecla=4'b1111, key_strobe=0, all counters and latches 0.
REQ-023 Reset asserted mid-press SHALL abort without a strobe; a key still held after reset is re-debounced from scratch.

Configuration
REQ-024 Macro KEYPAD_SYNC2_EN, when defined, SHALL pass row through a two-flop synchronizer (2 cycles of added latency).
REQ-025 When KEYPAD_SYNC2_EN is undefined, row SHALL pass through one register stage (1 cycle of added latency); all other behaviour is identical.

Structure
REQ-026 Package keypad_pkg SHALL hold KEY_NONE=4'b1111, the KEY_1..KEY_A code constants, and the state enum.
REQ-027 Sub-module keypad_debounce SHALL hold the saturating stable-level counter (inputs level, clear; output done); the top instantiates it once and shares it between DEBOUNCE and RELEASE.

Verification (SCAN_DIV=4, DEB_CYCLES=8)
REQ-028 Reset, then row=4'b1111 for 100 cycles -> col cycles 1110/1101/1011/0111 every 4 cycles, Tecla=4'b1111, no strobe.
REQ-029 Press '1' (row0 low only while col=1110) for 40 cycles, then release -> one strobe, Tecla=4'b1110 until 8 high cycles after release, then 4'b1111.
REQ-030 Press 'A' with 3-cycle bounce glitches, then held -> no strobe during bounce; a single strobe after 8 stable lows; Tecla=4'b1011.
REQ-031 Press D only -> Tecla stays 4'b1111 and no strobe.
REQ-032 '2' held, then '3' also pressed, then '2' released -> Tecla=4'b1101, then 4'b1111, then '3' detected with Tecla=4'b1100 and a second strobe.
REQ-033 Assert rst during DEBOUNCE of '1' -> no strobe, col=4'b1110, Tecla=4'b1111 on the next cycle.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants for the 4x4 keypad scanner.
//   KEY_* : active-low key codes (Tecla = ~(row*4+col+1)), KEY_NONE = no key.
//   ST_*  : scanner FSM state encoding.
//   key_code()   : key code from latched row/column.
//   lowest_low() : index of the lowest-numbered set bit of a row mask.
package keypad_pkg;

  localparam int unsigned ROW_W = 4;
  localparam int unsigned COL_W = 4;
  localparam int unsigned KEY_W = 4;

  localparam logic [KEY_W-1:0] KEY_NONE = 4'b1111;
  localparam logic [KEY_W-1:0] KEY_1    = 4'b1110;
  localparam logic [KEY_W-1:0] KEY_2    = 4'b1101;
  localparam logic [KEY_W-1:0] KEY_3    = 4'b1100;
  localparam logic [KEY_W-1:0] KEY_A    = 4'b1011;

  // Scanner states
  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // Code = ~(row*4 + col + 1); {r,c} is exactly row*4+col.
  function automatic logic [KEY_W-1:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return ~({r, c} + 4'd1);
  endfunction

  // Lowest-numbered asserted bit wins when several rows are low.
  function automatic logic [1:0] lowest_low(input logic [ROW_W-1:0] rows_low);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = ROW_W - 1; i >= 0; i--) begin
      if (rows_low[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: saturating counter of consecutive cycles with level=1.
//   clk, rst : clock, synchronous active-high reset
//   level    : qualifying condition this cycle
//   clear    : restart the count
//   done     : level is true and this is at least the DEB_CYCLES-th consecutive cycle
module keypad_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic clear,
  output logic done
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Counts qualifying cycles, holds at TERM instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear || !level) begin
      cnt <= '0;
    end else if (cnt != TERM) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign done = level && !clear && (cnt == TERM);

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce for the vending FSM.
//   clk        : clock
//   rst        : synchronous active-high reset
//   row[3:0]   : keypad rows, active-low (pulled up)
//   col[3:0]   : column drive, one-hot active-low
//   Tecla[3:0] : debounced key code, 4'b1111 = no key
//   key_strobe : one-cycle pulse when a key is accepted
// Build option: define KEYPAD_SYNC2_EN for a two-flop row synchronizer;
// otherwise rows pass through a single register stage.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] Tecla,
  output logic       key_strobe
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [3:0]    row_q;
  logic [1:0]    state, state_d;
  logic [SW-1:0] scan_cnt, scan_cnt_d;
  logic [3:0]    col_d;
  logic [1:0]    col_idx, col_idx_d;
  logic [1:0]    lat_row, lat_row_d;
  logic [1:0]    lat_col, lat_col_d;
  logic [3:0]    tecla_d;
  logic          strobe_d;
  logic          deb_level_c, deb_clear_c, deb_done;
  logic [3:0]    rows_low_c;
  logic          hit_c;
  logic          row_bit_c;

  // Row input staging
`ifdef KEYPAD_SYNC2_EN
  logic [3:0] row_s1;
  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1 <= 4'hF;
      row_q  <= 4'hF;
    end else begin
      row_s1 <= row;
      row_q  <= row_s1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) row_q <= 4'hF;
    else     row_q <= row;
  end
`endif

  // Key D (row3, col3) would encode as KEY_NONE, so it is masked out.
  always_comb begin
    rows_low_c = ~row_q;
    if (col_idx == 2'd3) rows_low_c[3] = 1'b0;
  end
  assign hit_c     = |rows_low_c;
  assign row_bit_c = row_q[lat_row];

  // Shared stable-level counter: lows in DEBOUNCE, highs in RELEASE.
  keypad_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk   (clk),
    .rst   (rst),
    .level (deb_level_c),
    .clear (deb_clear_c),
    .done  (deb_done)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SCAN;
      scan_cnt   <= '0;
      col        <= 4'b1110;
      col_idx    <= 2'd0;
      lat_row    <= 2'd0;
      lat_col    <= 2'd0;
      Tecla      <= KEY_NONE;
      key_strobe <= 1'b0;
    end else begin
      state      <= state_d;
      scan_cnt   <= scan_cnt_d;
      col        <= col_d;
      col_idx    <= col_idx_d;
      lat_row    <= lat_row_d;
      lat_col    <= lat_col_d;
      Tecla      <= tecla_d;
      key_strobe <= strobe_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    scan_cnt_d  = scan_cnt;
    col_d       = col;
    col_idx_d   = col_idx;
    lat_row_d   = lat_row;
    lat_col_d   = lat_col;
    tecla_d     = Tecla;
    strobe_d    = 1'b0;
    deb_level_c = 1'b0;
    deb_clear_c = 1'b0;

    case (state)
      ST_SCAN: begin
        deb_clear_c = 1'b1;
        if (scan_cnt == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (hit_c) begin
            lat_row_d = lowest_low(rows_low_c);
            lat_col_d = col_idx;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_d     = {col[2:0], col[3]};
            col_idx_d = col_idx + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt + SW'(1);
        end
      end

      ST_DEBOUNCE: begin
        deb_level_c = ~row_bit_c;
        if (row_bit_c) begin
          deb_clear_c = 1'b1;
          col_d       = {col[2:0], col[3]};
          col_idx_d   = col_idx + 2'd1;
          scan_cnt_d  = '0;
          state_d     = ST_SCAN;
        end else if (deb_done) begin
          tecla_d  = key_code(lat_row, lat_col);
          strobe_d = 1'b1;
          state_d  = ST_HELD;
        end
      end

      ST_HELD: begin
        deb_clear_c = 1'b1;
        if (row_bit_c) state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        deb_level_c = row_bit_c;
        if (!row_bit_c) begin
          deb_clear_c = 1'b1;
          state_d     = ST_HELD;
        end else if (deb_done) begin
          tecla_d    = KEY_NONE;
          col_d      = {col[2:0], col[3]};
          col_idx_d  = col_idx + 2'd1;
          scan_cnt_d = '0;
          state_d    = ST_SCAN;
        end
      end

      default: state_d = ST_SCAN;
    endcase
  end

endmodule
